// File: rtl/door_detector.sv
// Frame-rate door detector: debounces player presence in per-room door regions,
// emits a one-frame doorcode, a one-cycle spawn position, then a cooldown.
module door_detector #(
  parameter int          LEFT_EDGE       = 16,
  parameter int          RIGHT_EDGE      = 623,
  parameter int          TOP_EDGE        = 16,
  parameter int          BOTTOM_EDGE     = 463,
  parameter int          DOORY_LO        = 208,
  parameter int          DOORY_HI        = 271,
  parameter int          DOORX_LO        = 288,
  parameter int          DOORX_HI        = 351,
  parameter logic [31:0] DOOR_MASK       = 32'h0000_0012,
  parameter int          HOLD_FRAMES     = 2,
  parameter int          COOLDOWN_FRAMES = 30,
  parameter int          SPAWN_MARGIN    = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [9:0] player_x,
  input  logic [9:0] player_y,
  input  logic [2:0] room,
  output logic [2:0] doorcode,
  output logic       busy,
  output logic       spawn_valid,
  output logic [9:0] spawn_x,
  output logic [9:0] spawn_y
);

  localparam logic [9:0] X_LEFT   = 10'(LEFT_EDGE);
  localparam logic [9:0] X_RIGHT  = 10'(RIGHT_EDGE);
  localparam logic [9:0] Y_TOP    = 10'(TOP_EDGE);
  localparam logic [9:0] Y_BOTTOM = 10'(BOTTOM_EDGE);
  localparam logic [9:0] Y_LO     = 10'(DOORY_LO);
  localparam logic [9:0] Y_HI     = 10'(DOORY_HI);
  localparam logic [9:0] X_LO     = 10'(DOORX_LO);
  localparam logic [9:0] X_HI     = 10'(DOORX_HI);
  localparam logic [9:0] SPAWN_XR = 10'(RIGHT_EDGE - SPAWN_MARGIN);
  localparam logic [9:0] SPAWN_XL = 10'(LEFT_EDGE + SPAWN_MARGIN);
  localparam logic [9:0] SPAWN_YB = 10'(BOTTOM_EDGE - SPAWN_MARGIN);
  localparam logic [9:0] SPAWN_YT = 10'(TOP_EDGE + SPAWN_MARGIN);
  localparam logic [3:0] HOLD_4   = 4'(HOLD_FRAMES);
  localparam logic [7:0] COOL_8   = 8'(COOLDOWN_FRAMES);

  typedef enum logic [2:0] {
    S_PLAY, S_CONFIRM, S_EMIT, S_COOLDOWN, S_WAIT_CLEAR
  } state_t;

  state_t     state_reg, state_next;
  logic [2:0] code_reg, code_next;
  logic [3:0] hold_reg, hold_next;
  logic [7:0] cool_reg, cool_next;
  logic       leave_emit;

  logic [2:0] doorcode_next;
  logic       busy_next;
  logic [9:0] spawn_x_next, spawn_y_next;

  // Region decode
  logic [3:0] room_mask_arr [8];
  logic [3:0] room_mask;
  logic       in_left, in_right, in_top, in_bottom;
  logic [2:0] cand;

  for (genvar gi = 0; gi < 8; gi++) begin : g_mask
    assign room_mask_arr[gi] = DOOR_MASK[4*gi +: 4];
  end

  assign room_mask = room_mask_arr[room];
  assign in_left   = room_mask[0] && (player_x <= X_LEFT)
                     && (player_y >= Y_LO) && (player_y <= Y_HI);
  assign in_right  = room_mask[1] && (player_x >= X_RIGHT)
                     && (player_y >= Y_LO) && (player_y <= Y_HI);
  assign in_top    = room_mask[2] && (player_y <= Y_TOP)
                     && (player_x >= X_LO) && (player_x <= X_HI);
  assign in_bottom = room_mask[3] && (player_y >= Y_BOTTOM)
                     && (player_x >= X_LO) && (player_x <= X_HI);

  always_comb begin
    cand = 3'd0;
    if (in_left)        cand = 3'd1;
    else if (in_right)  cand = 3'd2;
    else if (in_top)    cand = 3'd3;
    else if (in_bottom) cand = 3'd4;
  end

  // State register, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_PLAY;
      code_reg    <= 3'd0;
      hold_reg    <= 4'd0;
      cool_reg    <= 8'd0;
      doorcode    <= 3'd0;
      busy        <= 1'b0;
      spawn_valid <= 1'b0;
      spawn_x     <= 10'd0;
      spawn_y     <= 10'd0;
    end else begin
      state_reg   <= state_next;
      code_reg    <= code_next;
      hold_reg    <= hold_next;
      cool_reg    <= cool_next;
      doorcode    <= doorcode_next;
      busy        <= busy_next;
      spawn_valid <= leave_emit;
      spawn_x     <= spawn_x_next;
      spawn_y     <= spawn_y_next;
    end
  end

  // Next-state logic; nothing moves except on a frame tick
  always_comb begin
    state_next = state_reg;
    code_next  = code_reg;
    hold_next  = hold_reg;
    cool_next  = cool_reg;
    leave_emit = 1'b0;
    if (frame_tick) begin
      case (state_reg)
        S_PLAY: begin
          if (cand != 3'd0) begin
            code_next  = cand;
            hold_next  = 4'd1;
            state_next = (HOLD_FRAMES == 1) ? S_EMIT : S_CONFIRM;
          end
        end
        S_CONFIRM: begin
          if (cand == code_reg) begin
            hold_next = hold_reg + 4'd1;
            if (hold_reg + 4'd1 >= HOLD_4) state_next = S_EMIT;
          end else begin
            hold_next  = 4'd0;
            state_next = S_PLAY;
          end
        end
        S_EMIT: begin
          hold_next  = 4'd0;
          cool_next  = COOL_8;
          leave_emit = 1'b1;
          state_next = S_COOLDOWN;
        end
        S_COOLDOWN: begin
          cool_next = cool_reg - 8'd1;
          if (cool_reg == 8'd1)
            state_next = (cand == 3'd0) ? S_PLAY : S_WAIT_CLEAR;
        end
        S_WAIT_CLEAR: begin
          if (cand == 3'd0) state_next = S_PLAY;
        end
        default: state_next = S_PLAY;
      endcase
    end
  end

  // Output decode from the next state so outputs land in registers
  always_comb begin
    doorcode_next = (state_next == S_EMIT) ? code_next : 3'd0;
    busy_next     = (state_next == S_EMIT) || (state_next == S_COOLDOWN);
    spawn_x_next  = spawn_x;
    spawn_y_next  = spawn_y;
    if (leave_emit) begin
      case (code_reg)
        3'd1:    begin spawn_x_next = SPAWN_XR; spawn_y_next = player_y; end
        3'd2:    begin spawn_x_next = SPAWN_XL; spawn_y_next = player_y; end
        3'd3:    begin spawn_x_next = player_x; spawn_y_next = SPAWN_YB; end
        3'd4:    begin spawn_x_next = player_x; spawn_y_next = SPAWN_YT; end
        default: begin spawn_x_next = spawn_x;  spawn_y_next = spawn_y;  end
      endcase
    end
  end

endmodule
